// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID register.
package if_fetch_stage_pkg;

    // PC and branch-target width; all PC arithmetic wraps modulo 2^PC_W.
    localparam int          PC_W       = 4;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

    // Number of cycles spent in FLUSH after a redirect.
    localparam logic [1:0]  FLUSH_CYCLES = 2'd1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/branch controls, instruction memory and IF/ID outputs.
interface if_fetch_stage_if;

    logic                                stall;
    logic                                PCSrc;
    logic [if_fetch_stage_pkg::PC_W-1:0] outAddEx;
    logic [31:0]                         instr;
    logic [if_fetch_stage_pkg::PC_W-1:0] PcOut;
    logic [if_fetch_stage_pkg::PC_W-1:0] PostPc;
    logic [31:0]                         InstrIFID;
    logic                                ValidIFID;
    logic                                halted;
    logic [7:0]                          branchCount;

    // Pipeline environment: hazard unit, MEM stage, instruction memory.
    modport master (
        output stall, PCSrc, outAddEx, instr,
        input  PcOut, PostPc, InstrIFID, ValidIFID, halted, branchCount
    );

    // Fetch stage itself.
    modport slave (
        input  stall, PCSrc, outAddEx, instr,
        output PcOut, PostPc, InstrIFID, ValidIFID, halted, branchCount
    );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load, flush-to-bubble, otherwise hold.
module if_id_reg
    import if_fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [PC_W-1:0] i_post_pc,
    input  logic [31:0]     i_instr,
    output logic [PC_W-1:0] o_post_pc,
    output logic [31:0]     o_instr,
    output logic            o_valid
);

    logic [PC_W-1:0] r_post_pc;
    logic [31:0]     r_instr;
    logic            r_valid;

    // Flush beats load; a bubble leaves PostPc untouched since it is not read when invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_post_pc <= '0;
            r_instr   <= NOP_BUBBLE;
            r_valid   <= 1'b0;
        end else if (i_flush) begin
            r_instr   <= NOP_BUBBLE;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_post_pc <= i_post_pc;
            r_instr   <= i_instr;
            r_valid   <= 1'b1;
        end
    end

    assign o_post_pc = r_post_pc;
    assign o_instr   = r_instr;
    assign o_valid   = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC ownership, redirect, stall, halt and IF/ID feed.
//
// state | meaning
// RUN   | fetch sequentially, PC+1 each unstalled cycle
// FLUSH | first cycle after a redirect; IF/ID holds the squashed bubble
// HALT  | halt word seen; PC frozen, IF/ID drains to bubbles
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    if_fetch_stage_if.slave    fif
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_halted;
    logic [7:0]      r_branch_cnt;
    logic [1:0]      r_flush_cnt;

    logic [PC_W-1:0] w_pc_inc;
    logic            w_halt_fetch;
    logic            w_ifid_load;
    logic            w_ifid_flush;

    assign w_pc_inc     = r_pc + 1'b1;
    assign w_halt_fetch = (fif.instr == HALT_WORD);

    // IF/ID control: a redirect squashes, HALT drains, otherwise load unless stalled.
    always_comb begin
        w_ifid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        if (fif.PCSrc) begin
            w_ifid_flush = 1'b1;
        end else if (r_state == HALT) begin
            w_ifid_flush = 1'b1;
        end else if (!fif.stall) begin
            w_ifid_load = 1'b1;
        end
    end

    // Fetch FSM with PC, halt flag, redirect counter and flush timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= RUN;
            r_pc         <= '0;
            r_halted     <= 1'b0;
            r_branch_cnt <= 8'd0;
            r_flush_cnt  <= 2'd0;
        end else if (fif.PCSrc) begin
            r_state      <= FLUSH;
            r_pc         <= fif.outAddEx;
            r_halted     <= 1'b0;
            r_branch_cnt <= sat_inc8(r_branch_cnt);
            r_flush_cnt  <= FLUSH_CYCLES;
        end else begin
            case (r_state)
                RUN: begin
                    if (!fif.stall) begin
                        if (w_halt_fetch) begin
                            r_state <= HALT;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                FLUSH: begin
                    if (!fif.stall) begin
                        r_flush_cnt <= r_flush_cnt - 2'd1;
                        if (w_halt_fetch) begin
                            r_state     <= HALT;
                            r_flush_cnt <= 2'd0;
                        end else begin
                            r_pc <= w_pc_inc;
                            if (r_flush_cnt == 2'd1) begin
                                r_state <= RUN;
                            end
                        end
                    end
                end
                HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_ifid_load),
        .i_flush   (w_ifid_flush),
        .i_post_pc (w_pc_inc),
        .i_instr   (fif.instr),
        .o_post_pc (fif.PostPc),
        .o_instr   (fif.InstrIFID),
        .o_valid   (fif.ValidIFID)
    );

    assign fif.PcOut       = r_pc;
    assign fif.halted      = r_halted;
    assign fif.branchCount = r_branch_cnt;

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the program counter, produces the incremented PC (PostPc) consumed by the EX-stage branch-target adder, and accepts that adder's result back as the redirect target when the branch resolves. Drives the instruction-memory address and the IF/ID pipeline register. Handles hazard stalls, taken-branch flushes and program halt.

## Interface

Parameters:
- PC_W, 4, PC and branch-target width; all PC arithmetic is modulo 2^PC_W.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- stall  input  1  hazard-unit hold: PC and IF/ID keep their values.
- PCSrc  input  1  taken branch, asserted by MEM stage for one cycle.
- outAddEx  input  PC_W  branch target from the EX-stage adder, valid with PCSrc.
- instr  input  32  instruction-memory read data for PcOut, combinational (same cycle).
- PcOut  output  PC_W  instruction-memory address (current PC).
- PostPc  output  PC_W  IF/ID register: PC+1 of the fetched instruction.
- InstrIFID  output  32  IF/ID register: fetched instruction.
- ValidIFID  output  1  IF/ID register holds a real instruction (0 = bubble, InstrIFID = 0).
- halted  output  1  fetch stopped on HALT_WORD.
- branchCount  output  8  taken redirects since reset, saturating at 255.

## Operation

- States: RUN, FLUSH, HALT. Reset enters RUN.
- Reset values: PcOut=0, PostPc=0, InstrIFID=0, ValidIFID=0, halted=0, branchCount=0, flush counter=0.
- RUN, no events: PC <= PC+1 (wraps 2^PC_W-1 -> 0); PostPc <= PC+1; InstrIFID <= instr; ValidIFID <= 1.
- Fetched instr == HALT_WORD (RUN, no stall, no PCSrc): IF/ID loads it with ValidIFID=1, PC holds, go HALT; halted=1 from next cycle.
- HALT: PC and IF/ID frozen, except IF/ID bubbles after one cycle (ValidIFID=0, InstrIFID=0) so the halt word propagates once. Left only by reset or PCSrc.
- PCSrc (any state): PC <= outAddEx; IF/ID <= bubble; branchCount += 1 (saturating); go FLUSH with counter=1; halted <= 0.
- FLUSH: one cycle; fetches normally from the new PC but IF/ID already holds the squashed bubble; returns to RUN next cycle. A second PCSrc in FLUSH restarts redirect (new target wins, count increments again).
- Flushing of ID/EX and EX/MEM is owned by downstream stages, not this block.
- Priority, highest first: reset > PCSrc > stall > halt detection. PCSrc overrides stall in the same cycle. stall in HALT has no effect.
- outAddEx ignored when PCSrc=0. Target arithmetic already truncated to PC_W by the adder; no extension here.

## Timing

- PcOut updates one cycle after the controlling event (increment, redirect).
- Fetch-to-IF/ID latency: 1 cycle; instr sampled at the edge where PcOut addresses it.
- PCSrc at edge N: PcOut=outAddEx after N; first valid instruction from target in IF/ID after N+1.
- stall held k cycles: PC and IF/ID unchanged for exactly k edges; resumes with no lost or duplicated instruction.
- Reset mid-FLUSH or mid-HALT: all outputs to reset values at that edge, state RUN.
- halted rises the edge after HALT_WORD is loaded into IF/ID.

## Structure

- Shared pipeline package: PC_W, HALT_WORD, the fetch-state enumeration (RUN/FLUSH/HALT), NOP/bubble constant 32'h0.
- Sub-module: if_id_reg (IF/ID register with load, flush-to-bubble and hold inputs), reused pattern for later stage registers.
- PC incrementer stays inline; no instance of the EX adder here.

## Test plan

- Reset then 20 free-running cycles, memory returns instr=PC: PcOut 0,1,…,15,0,1… (wrap), PostPc = PcOut_prev+1, ValidIFID=1 from cycle 2.
- stall high 3 cycles at PC=5: PcOut stays 5, IF/ID holds instruction 4 three edges, then PC=6 with no gaps.
- PCSrc with outAddEx=12 at PC=7: PcOut=12 next cycle, one bubble (ValidIFID=0), next IF/ID = instr@12, PostPc=13, branchCount=1.
- PCSrc and stall same cycle, outAddEx=3: redirect wins, PcOut=3; back-to-back PCSrc (9 then 2): PcOut=2, branchCount +2.
- instr=HALT_WORD at PC=4: halted=1, PcOut frozen at 4, one valid halt word then bubbles; subsequent PCSrc to 0 resumes at 0, halted=0.
- Reset asserted during FLUSH and during HALT: all outputs 0 next edge, branchCount=0; 300 taken branches: branchCount saturates at 255.
